// File: rtl/ex_stage_pkg.sv
// Shared widths, op codes and divider state encoding for the execute stage.
package ex_stage_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int OP_W     = 5;
  localparam int BYPASS_W = DATA_W + REG_W + 1;

  localparam logic [OP_W-1:0] OP_ADD     = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB     = 5'd1;
  localparam logic [OP_W-1:0] OP_SLT     = 5'd2;
  localparam logic [OP_W-1:0] OP_SLTU    = 5'd3;
  localparam logic [OP_W-1:0] OP_AND     = 5'd4;
  localparam logic [OP_W-1:0] OP_OR      = 5'd5;
  localparam logic [OP_W-1:0] OP_NOR     = 5'd6;
  localparam logic [OP_W-1:0] OP_XOR     = 5'd7;
  localparam logic [OP_W-1:0] OP_SLL     = 5'd8;
  localparam logic [OP_W-1:0] OP_SRL     = 5'd9;
  localparam logic [OP_W-1:0] OP_SRA     = 5'd10;
  localparam logic [OP_W-1:0] OP_LU12I   = 5'd11;
  localparam logic [OP_W-1:0] OP_MUL_W   = 5'd12;
  localparam logic [OP_W-1:0] OP_MULH_W  = 5'd13;
  localparam logic [OP_W-1:0] OP_MULH_WU = 5'd14;
  localparam logic [OP_W-1:0] OP_DIV_W   = 5'd15;
  localparam logic [OP_W-1:0] OP_MOD_W   = 5'd16;
  localparam logic [OP_W-1:0] OP_DIV_WU  = 5'd17;
  localparam logic [OP_W-1:0] OP_MOD_WU  = 5'd18;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op >= OP_DIV_W) && (op <= OP_MOD_WU);
  endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Iterative radix-2 restoring divider: operands are made positive on start,
// one quotient bit per cycle, signs restored when the FSM sits in DONE.
module ex_div
  import ex_stage_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              start,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              busy,
  input  logic              ack
);

  localparam int CNT_W = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_ITERS - 1);

  div_state_e state, state_next;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] q_reg, r_reg, dvs;
  logic              sign1, sign2, div_zero;
  logic [DATA_W:0]   shifted, diff;
  logic              qbit;
  logic              s1_neg, s2_neg;

  assign s1_neg = signed_op & src1[DATA_W-1];
  assign s2_neg = signed_op & src2[DATA_W-1];

  // Partial remainder stays below the divisor, so 33 bits hold the trial subtract.
  assign shifted = {r_reg, q_reg[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign qbit    = ~diff[DATA_W];

  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (start) state_next = DIV_BUSY;
      DIV_BUSY: if (count == LAST) state_next = DIV_DONE;
      DIV_DONE: if (ack) state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
    if (flush) state_next = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= DIV_IDLE;
      count    <= '0;
      q_reg    <= '0;
      r_reg    <= '0;
      dvs      <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (flush) begin
        count <= '0;
      end else if (state == DIV_IDLE && start) begin
        count    <= '0;
        q_reg    <= s1_neg ? (~src1 + 32'd1) : src1;
        dvs      <= s2_neg ? (~src2 + 32'd1) : src2;
        r_reg    <= '0;
        sign1    <= s1_neg;
        sign2    <= s2_neg;
        div_zero <= (src2 == '0);
      end else if (state == DIV_BUSY) begin
        count <= count + CNT_W'(1);
        q_reg <= {q_reg[DATA_W-2:0], qbit};
        r_reg <= qbit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      end
    end
  end

  // A zero divisor leaves the dividend magnitude in r_reg; only the quotient needs forcing.
  assign quotient  = div_zero ? '1 : ((sign1 ^ sign2) ? (~q_reg + 32'd1) : q_reg);
  assign remainder = sign1 ? (~r_reg + 32'd1) : r_reg;
  assign done      = (state == DIV_DONE);
  assign busy      = (state != DIV_IDLE);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/multiply, iterative divide, registered
// result toward MEM under valid/ready, killed by exception or ERTN flush.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                excp_flush,
  input  logic                ertn_flush,
  input  logic                left_valid,
  output logic                left_ready,
  output logic                right_valid,
  input  logic                right_ready,
  output logic                is_fire,
  input  logic [OP_W-1:0]     in_op,
  input  logic [DATA_W-1:0]   in_src1,
  input  logic [DATA_W-1:0]   in_src2,
  input  logic [DATA_W-1:0]   in_pc,
  input  logic [REG_W-1:0]    in_wreg_index,
  input  logic                in_wreg_en,
  output logic [DATA_W-1:0]   out_result,
  output logic [DATA_W-1:0]   out_pc,
  output logic [REG_W-1:0]    out_wreg_index,
  output logic                out_wreg_en,
  output logic [BYPASS_W-1:0] ex_bypass,
  output logic                div_busy
);

  logic              flush, is_div, result_ready, signed_div;
  logic              div_done;
  logic [DATA_W-1:0] div_quotient, div_remainder;
  logic [DATA_W-1:0] result, mulh_s;
  logic [63:0]       prod_u;
  logic [4:0]        sh;

  assign flush      = excp_flush | ertn_flush;
  assign is_div     = is_div_op(in_op);
  assign signed_div = (in_op == OP_DIV_W) || (in_op == OP_MOD_W);
  assign sh         = in_src2[4:0];

  // One unsigned multiplier; the signed high word is corrected from it.
  assign prod_u = {32'd0, in_src1} * {32'd0, in_src2};
  assign mulh_s = prod_u[63:32] - (in_src1[31] ? in_src2 : 32'd0)
                                - (in_src2[31] ? in_src1 : 32'd0);

  always_comb begin
    result = '0;
    case (in_op)
      OP_ADD:     result = in_src1 + in_src2;
      OP_SUB:     result = in_src1 - in_src2;
      OP_SLT:     result = {31'd0, $signed(in_src1) < $signed(in_src2)};
      OP_SLTU:    result = {31'd0, in_src1 < in_src2};
      OP_AND:     result = in_src1 & in_src2;
      OP_OR:      result = in_src1 | in_src2;
      OP_NOR:     result = ~(in_src1 | in_src2);
      OP_XOR:     result = in_src1 ^ in_src2;
      OP_SLL:     result = in_src1 << sh;
      OP_SRL:     result = in_src1 >> sh;
      OP_SRA:     result = $signed(in_src1) >>> sh;
      OP_LU12I:   result = in_src2;
      OP_MUL_W:   result = prod_u[31:0];
      OP_MULH_W:  result = mulh_s;
      OP_MULH_WU: result = prod_u[63:32];
      OP_DIV_W, OP_DIV_WU: result = div_quotient;
      OP_MOD_W, OP_MOD_WU: result = div_remainder;
      default:    result = '0;
    endcase
  end

  ex_div #(.DIV_ITERS(DIV_ITERS)) u_div (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .start     (left_valid & is_div),
    .signed_op (signed_div),
    .src1      (in_src1),
    .src2      (in_src2),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder),
    .busy      (div_busy),
    .ack       (is_fire)
  );

  assign result_ready = ~is_div | div_done;
  assign is_fire      = left_valid & result_ready & right_ready & ~flush;
  assign left_ready   = (result_ready & right_ready) | ~left_valid;
  assign ex_bypass    = {result, in_wreg_index, in_wreg_en & left_valid & result_ready};

  always_ff @(posedge clk) begin
    if (reset) begin
      right_valid    <= 1'b0;
      out_result     <= '0;
      out_pc         <= '0;
      out_wreg_index <= '0;
      out_wreg_en    <= 1'b0;
    end else if (flush) begin
      right_valid <= 1'b0;
    end else if (is_fire) begin
      right_valid    <= 1'b1;
      out_result     <= result;
      out_pc         <= in_pc;
      out_wreg_index <= in_wreg_index;
      out_wreg_en    <= in_wreg_en;
    end else if (right_ready) begin
      right_valid <= 1'b0;
    end
  end

endmodule
